// File: rtl/emulador_sensores.sv
// Scripted stimulus source for the lighting controller: emulates the IR presence
// sensor (long pulse or LFSR-driven burst) and a bouncing push button.
module emulador_sensores #(
  parameter int unsigned PULSO_LONGO   = 10000,
  parameter int unsigned ESPERA_LONGA  = 30001,
  parameter int unsigned ESTAB         = 4,
  parameter int unsigned DUR_MAX       = 30,
  parameter int unsigned INTERV_MAX    = 30000,
  parameter int unsigned N_REPETICOES  = 10,
  parameter int unsigned BOUNCE_CICLOS = 8,
  parameter int unsigned PRESS_CICLOS  = 400,
  parameter logic [15:0] SEMENTE       = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] modo,
  output logic       infravermelho,
  output logic       push_button,
  output logic       busy,
  output logic       done,
  output logic [3:0] contagem
);

  typedef enum logic [2:0] {OCIOSO, PULSO, ESTABILIZA, INTERVALO, BOUNCE, FIRME, FIM} estado_t;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned DMAX = max2(max2(max2(PULSO_LONGO, ESPERA_LONGA), max2(ESTAB, DUR_MAX)),
                                      max2(max2(INTERV_MAX, BOUNCE_CICLOS), PRESS_CICLOS));
  localparam int CW = $clog2(DMAX) + 1;
  localparam logic [15:0] SEED = (SEMENTE == 16'h0000) ? 16'h0001 : SEMENTE;

  estado_t       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   lfsr_q, lfsr_d, lfsr_nxt;
  logic [1:0]    modo_q, modo_d;
  logic [3:0]    contagem_q, contagem_d;
  logic          ir_q, ir_d, push_q, push_d, busy_q, busy_d, done_q, done_d;
  logic [CW-1:0] dur_rand, int_rand;
  logic          ultimo;

  // Galois step; the current value is what a draw consumes, then it advances.
  assign lfsr_nxt = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign ultimo   = (cnt_q == CW'(1));

  always_comb begin
    dur_rand = CW'(lfsr_q[7:0]) + CW'(1);
    if (lfsr_q[7:0] >= 8'(DUR_MAX - 1)) dur_rand = CW'(DUR_MAX);
    int_rand = CW'(lfsr_q) + CW'(1);
    if (lfsr_q >= 16'(INTERV_MAX - 1)) int_rand = CW'(INTERV_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OCIOSO;
      cnt_q      <= '0;
      lfsr_q     <= SEED;
      modo_q     <= 2'b00;
      contagem_q <= 4'd0;
      ir_q       <= 1'b0;
      push_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      modo_q     <= modo_d;
      contagem_q <= contagem_d;
      ir_q       <= ir_d;
      push_q     <= push_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = ultimo ? cnt_q : cnt_q - CW'(1);
    lfsr_d     = lfsr_q;
    modo_d     = modo_q;
    contagem_d = contagem_q;
    case (state_q)
      OCIOSO: begin
        cnt_d = cnt_q;
        if (start && modo != 2'b11) begin
          modo_d     = modo;
          contagem_d = 4'd1;
          if (modo == 2'b10) begin
            state_d = BOUNCE;
            cnt_d   = CW'(BOUNCE_CICLOS);
          end else begin
            state_d = PULSO;
            if (modo == 2'b00) cnt_d = CW'(PULSO_LONGO);
            else begin
              cnt_d  = dur_rand;
              lfsr_d = lfsr_nxt;
            end
          end
        end
      end
      PULSO: if (ultimo) begin
        state_d = ESTABILIZA;
        cnt_d   = CW'(ESTAB);
      end
      ESTABILIZA: if (ultimo) begin
        state_d = INTERVALO;
        if (modo_q == 2'b00) cnt_d = CW'(ESPERA_LONGA);
        else begin
          cnt_d  = int_rand;
          lfsr_d = lfsr_nxt;
        end
      end
      INTERVALO: if (ultimo) begin
        if (modo_q == 2'b01 && contagem_q < 4'(N_REPETICOES)) begin
          state_d    = PULSO;
          cnt_d      = dur_rand;
          lfsr_d     = lfsr_nxt;
          contagem_d = contagem_q + 4'd1;
        end else state_d = FIM;
      end
      BOUNCE: if (ultimo) begin
        state_d = FIRME;
        cnt_d   = CW'(PRESS_CICLOS);
      end
      FIRME:   if (ultimo) state_d = FIM;
      FIM:     state_d = OCIOSO;
      default: state_d = OCIOSO;
    endcase
  end

  // Output flops are loaded from the next state so they line up with state_q.
  always_comb begin
    ir_d   = (state_d == PULSO);
    busy_d = (state_d != OCIOSO);
    done_d = (state_d == FIM);
    push_d = (state_d == FIRME);
    if (state_d == BOUNCE) push_d = (state_q == BOUNCE) ? ~push_q : 1'b1;
  end

  assign infravermelho = ir_q;
  assign push_button   = push_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign contagem      = contagem_q;

endmodule
